adxl362_fifo_ctrl: RTL

Parametrised synchronous sample FIFO for the ADXL362 behavioural model. It is the successor to the fixed 16x512 FIFO and adds programmable depth, an occupancy count and a watermark flag. It also adds the sensor's FIFO modes: disabled, oldest-saved and stream (overwrite oldest), plus sticky overrun and underrun flags. It sits between the sample generator (write side) and the SPI register/readout logic (read side). Everything is on one clock.

---
 rtl/adxl362_fifo_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/adxl362_fifo_ctrl.sv
// Sample FIFO with occupancy count, watermark flag, disabled/oldest-saved/stream modes and sticky overrun/underrun; optional drop counter under ADXL362_FIFO_DROP_CNT_EN.
// Latency: write to rd_data is 1 cycle when empty (first-word-fall-through); all flags follow registered count one cycle after the causing edge.
// Backpressure: none on the write side; when full, oldest-saved drops the new sample and stream overwrites the oldest one.
module adxl362_fifo_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] watermark,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             wm_hit,
    output logic             overrun,
    output logic             underrun,
    output logic [7:0]       drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             ovr_q;
    logic             udr_q;

    logic enabled;
    logic is_empty;
    logic is_full;
    logic do_wr;
    logic do_rd;
    logic ovr_evt;
    logic udr_evt;

    assign enabled  = (mode != 2'b00);
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    always_comb begin
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        ovr_evt = 1'b0;
        udr_evt = 1'b0;
        if (!enabled) begin
            udr_evt = rd_en;
        end else if (wr_en && rd_en) begin
            // Simultaneous pop and push: when empty the read has nothing to take.
            do_wr   = 1'b1;
            do_rd   = !is_empty;
            udr_evt = is_empty;
        end else if (wr_en) begin
            if (!is_full) begin
                do_wr = 1'b1;
            end else begin
                ovr_evt = 1'b1;
                if (mode == 2'b10) begin
                    do_wr = 1'b1;
                    do_rd = 1'b1;
                end
            end
        end else if (rd_en) begin
            do_rd   = !is_empty;
            udr_evt = is_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr_q  <= 1'b0;
            udr_q  <= 1'b0;
        end else begin
            if (!enabled) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + PW'(1);
                if (do_rd) rd_ptr <= rd_ptr + PW'(1);
                cnt <= cnt + CNT_W'(do_wr) - CNT_W'(do_rd);
            end
            if (ovr_evt) ovr_q <= 1'b1;
            if (udr_evt) udr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_wr) mem[wr_ptr] <= wr_data;
    end

`ifdef ADXL362_FIFO_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            drop_q <= 8'd0;
        end else if (ovr_evt && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

    assign rd_data  = mem[rd_ptr];
    assign count    = cnt;
    assign empty    = is_empty;
    assign full     = is_full;
    assign wm_hit   = (watermark != '0) && (cnt >= watermark);
    assign overrun  = ovr_q;
    assign underrun = udr_q;

endmodule
